// File: rtl/odometer_pkg.sv
// Shared types and defaults for the ring-oscillator odometer measurement block.
package odometer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRESS,
    SETTLE,
    WAIT_EDGE,
    COUNT,
    NEXT
  } state_t;

  localparam int SETTLE_CYC_DEFAULT = 4;

  // Channel-index width; a single channel still gets a 1-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/odometer_beat_timer.sv
// Rising-edge detect, beat-period counter with saturation, and wait-for-edge timeout
// for the currently selected channel's beat.
module odometer_beat_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             beat,
  input  logic             clear,
  input  logic             waiting,
  input  logic             counting,
  output logic             rise,
  output logic             sat,
  output logic             timeout,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_MAX_M1 = ~(CNT_W'(1));

  logic             prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] wait_reg;

  assign rise    = beat & ~prev_reg;
  assign sat     = (cnt_reg == CNT_MAX);
  assign timeout = waiting && (wait_reg == CNT_MAX_M1);
  assign count   = cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg <= 1'b0;
      cnt_reg  <= '0;
      wait_reg <= '0;
    end else begin
      prev_reg <= clear ? 1'b0 : beat;

      if (clear) begin
        wait_reg <= '0;
      end else if (waiting) begin
        wait_reg <= wait_reg + CNT_W'(1);
      end

      // The first edge starts the period at 1 so the second edge lands on the period itself.
      if (clear) begin
        cnt_reg <= '0;
      end else if (waiting && rise) begin
        cnt_reg <= CNT_W'(1);
      end else if (counting && !sat) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/odometer_multi_meas.sv
// Sequences stress and per-channel beat-period measurement across a bank of
// stress/reference ring-oscillator pairs; all outputs come straight from flops.
module odometer_multi_meas
  import odometer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 12,
  parameter int STRESS_W   = 16,
  parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT,
  localparam int SEL_W     = sel_width(NUM_CH)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                STOP,
  input  logic                CONTINUOUS,
  input  logic                AC_DC,
  input  logic [NUM_CH-1:0]   CH_EN,
  input  logic [STRESS_W-1:0] STRESS_CYCLES,
  input  logic [NUM_CH-1:0]   BEAT,
  output logic [NUM_CH-1:0]   EN_POWER_ROSC_STRESS,
  output logic                EN_ROSC,
  output logic                MEAS_STRESS,
  output logic                AC_DC_LATCHED,
  output logic [SEL_W-1:0]    SEL_CH,
  output logic [CNT_W-1:0]    BF_COUNT,
  output logic [SEL_W-1:0]    BF_CH,
  output logic                BF_VALID,
  output logic                BF_OVF,
  output logic                BUSY
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    ch_reg, ch_next;
  logic [NUM_CH-1:0]   mask_reg, mask_next;
  logic                cont_reg, cont_next;
  logic                acdc_reg, acdc_next;
  logic [STRESS_W-1:0] stress_len_reg, stress_len_next;
  logic [STRESS_W-1:0] stress_cnt_reg, stress_cnt_next;
  logic [SET_W-1:0]    settle_cnt_reg, settle_cnt_next;

  logic             res_valid, res_ovf;
  logic [CNT_W-1:0] res_count;
  logic             hist_clear;
  logic             t_rise, t_sat, t_timeout;
  logic [CNT_W-1:0] t_count;
  logic [SEL_W:0]   lo_hit, nx_hit, st_hit;

  // Lowest set bit of m at or above index from; MSB of the result flags a hit.
  function automatic logic [SEL_W:0] find_from(input logic [NUM_CH-1:0] m, input int from);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  assign lo_hit = find_from(mask_reg, 0);
  assign nx_hit = find_from(mask_reg, int'(ch_reg) + 1);
  assign st_hit = find_from(CH_EN, 0);

  odometer_beat_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (CLK),
    .srst    (RESET),
    .beat    (BEAT[ch_reg]),
    .clear   (hist_clear),
    .waiting (state_reg == WAIT_EDGE),
    .counting(state_reg == COUNT),
    .rise    (t_rise),
    .sat     (t_sat),
    .timeout (t_timeout),
    .count   (t_count)
  );

  always_comb begin
    state_next      = state_reg;
    ch_next         = ch_reg;
    mask_next       = mask_reg;
    cont_next       = cont_reg;
    acdc_next       = acdc_reg;
    stress_len_next = stress_len_reg;
    stress_cnt_next = stress_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    res_valid       = 1'b0;
    res_ovf         = 1'b0;
    res_count       = t_count;
    hist_clear      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (START && (CH_EN != '0)) begin
          mask_next       = CH_EN;
          cont_next       = CONTINUOUS;
          acdc_next       = AC_DC;
          stress_len_next = STRESS_CYCLES;
          stress_cnt_next = '0;
          settle_cnt_next = '0;
          ch_next         = st_hit[SEL_W-1:0];
          state_next      = (STRESS_CYCLES == '0) ? SETTLE : STRESS;
        end
      end
      STRESS: begin
        if (stress_cnt_reg == stress_len_reg - STRESS_W'(1)) begin
          ch_next         = lo_hit[SEL_W-1:0];
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end else begin
          stress_cnt_next = stress_cnt_reg + STRESS_W'(1);
        end
      end
      SETTLE: begin
        if (settle_cnt_reg == SET_W'(SETTLE_CYC - 1)) begin
          hist_clear = 1'b1;
          state_next = WAIT_EDGE;
        end else begin
          settle_cnt_next = settle_cnt_reg + SET_W'(1);
        end
      end
      WAIT_EDGE: begin
        if (t_rise) begin
          state_next = COUNT;
        end else if (t_timeout) begin
          res_valid  = 1'b1;
          res_ovf    = 1'b1;
          res_count  = '1;
          state_next = NEXT;
        end
      end
      COUNT: begin
        // A counter pinned at all-ones is reported as saturated even if an edge arrives with it.
        if (t_sat) begin
          res_valid  = 1'b1;
          res_ovf    = 1'b1;
          res_count  = '1;
          state_next = NEXT;
        end else if (t_rise) begin
          res_valid  = 1'b1;
          state_next = NEXT;
        end
      end
      NEXT: begin
        settle_cnt_next = '0;
        if (nx_hit[SEL_W]) begin
          ch_next    = nx_hit[SEL_W-1:0];
          state_next = SETTLE;
        end else if (cont_reg) begin
          ch_next         = lo_hit[SEL_W-1:0];
          stress_cnt_next = '0;
          state_next      = (stress_len_reg == '0) ? SETTLE : STRESS;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (STOP && (state_reg != IDLE)) begin
      state_next = IDLE;
      res_valid  = 1'b0;
      res_ovf    = 1'b0;
    end
  end

  assign SEL_CH        = ch_reg;
  assign AC_DC_LATCHED = acdc_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg            <= IDLE;
      ch_reg               <= '0;
      mask_reg             <= '0;
      cont_reg             <= 1'b0;
      acdc_reg             <= 1'b0;
      stress_len_reg       <= '0;
      stress_cnt_reg       <= '0;
      settle_cnt_reg       <= '0;
      EN_POWER_ROSC_STRESS <= '0;
      EN_ROSC              <= 1'b0;
      MEAS_STRESS          <= 1'b0;
      BF_COUNT             <= '0;
      BF_CH                <= '0;
      BF_VALID             <= 1'b0;
      BF_OVF               <= 1'b0;
      BUSY                 <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ch_reg         <= ch_next;
      mask_reg       <= mask_next;
      cont_reg       <= cont_next;
      acdc_reg       <= acdc_next;
      stress_len_reg <= stress_len_next;
      stress_cnt_reg <= stress_cnt_next;
      settle_cnt_reg <= settle_cnt_next;

      // Output flops track the state being entered so they line up with state_reg.
      EN_POWER_ROSC_STRESS <= (state_next == STRESS) ? mask_next : '0;
      EN_ROSC              <= (state_next != IDLE);
      MEAS_STRESS          <= (state_next inside {SETTLE, WAIT_EDGE, COUNT, NEXT});
      BUSY                 <= (state_next != IDLE);
      BF_VALID             <= res_valid;
      BF_OVF               <= res_valid & res_ovf;
      if (res_valid) begin
        BF_COUNT <= res_count;
        BF_CH    <= ch_reg;
      end
    end
  end

endmodule

// File: tb/tb_odometer_multi_meas.sv
// Randomised bench for odometer_multi_meas: pulse-train beats, expected results
// derived from each channel's beat period and the enable mask.
module tb_odometer_multi_meas;

  localparam int NCH     = 4;
  localparam int CMAX    = 4095;
  localparam int SETTLE  = 4;

  logic        clk = 1'b0;
  logic        reset, start, stop, continuous, ac_dc;
  logic [3:0]  ch_en;
  logic [15:0] stress_cycles;
  logic [3:0]  beat;
  logic [3:0]  en_power;
  logic        en_rosc, meas, acdc_lat;
  logic [1:0]  sel_ch;
  logic [11:0] bf_count;
  logic [1:0]  bf_ch;
  logic        bf_valid, bf_ovf, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int period[NCH];
  int phase[NCH];
  logic [3:0] force_beat = 4'b0;
  logic [3:0] last_beat  = 4'b0;

  typedef struct {
    int ch;
    int cnt;
    bit ovf;
  } res_t;
  res_t exp_q[$];

  always #5 clk = ~clk;

  odometer_multi_meas dut (
    .CLK                 (clk),
    .RESET               (reset),
    .START               (start),
    .STOP                (stop),
    .CONTINUOUS          (continuous),
    .AC_DC               (ac_dc),
    .CH_EN               (ch_en),
    .STRESS_CYCLES       (stress_cycles),
    .BEAT                (beat),
    .EN_POWER_ROSC_STRESS(en_power),
    .EN_ROSC             (en_rosc),
    .MEAS_STRESS         (meas),
    .AC_DC_LATCHED       (acdc_lat),
    .SEL_CH              (sel_ch),
    .BF_COUNT            (bf_count),
    .BF_CH               (bf_ch),
    .BF_VALID            (bf_valid),
    .BF_OVF              (bf_ovf),
    .BUSY                (busy)
  );

  // One cycle: outputs are sampled at the falling edge, then the next beat sample is driven.
  task automatic tick();
    logic [3:0] b;
    @(negedge clk);
    last_beat = beat;
    cyc++;
    for (int c = 0; c < NCH; c++)
      b[c] = force_beat[c] || (period[c] != 0 && ((cyc + phase[c]) % period[c]) == 0);
    beat = b;
  endtask

  task automatic run_and_check(input string tag, input logic [3:0] mask, input int stress,
                               input bit poke, output int first_lat);
    res_t e;
    int t, stress_seen, viol;
    bit done, acdc_exp;
    logic [1:0]  exp_ch;
    logic [11:0] exp_cnt;
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        e.ch  = c;
        e.ovf = (period[c] == 0 || period[c] >= CMAX);
        e.cnt = e.ovf ? CMAX : period[c];
        exp_q.push_back(e);
      end
    end
    acdc_exp      = 1'($urandom_range(0, 1));
    ac_dc         = acdc_exp;
    ch_en         = mask;
    stress_cycles = 16'(stress);
    continuous    = 1'b0;
    start         = 1'b1;
    tick();
    start = 1'b0;
    ch_en = 4'b0;
    ac_dc = ~acdc_exp;
    t = 1; stress_seen = 0; viol = 0; first_lat = -1; done = 0;
    n_vec++;
    if (busy !== 1'b1 || acdc_lat !== acdc_exp) begin
      n_err++;
      $display("FAIL %s start: busy=%b acdc=%b, required busy=1 acdc=%b", tag, busy, acdc_lat, acdc_exp);
    end
    while (!done && t < 30000) begin
      if (en_power != 4'b0) begin
        stress_seen++;
        if (en_power !== mask || meas !== 1'b0 || en_rosc !== 1'b1) viol++;
      end
      if (bf_valid === 1'b1) begin
        if (first_lat < 0) first_lat = t;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s extra result: ch=%0d cnt=%0d ovf=%b, required none", tag, bf_ch, bf_count, bf_ovf);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          exp_ch  = e.ch[1:0];
          exp_cnt = e.cnt[11:0];
          if (bf_ch !== exp_ch || bf_count !== exp_cnt || bf_ovf !== e.ovf) begin
            n_err++;
            $display("FAIL %s result: ch=%0d cnt=%0d ovf=%b, required ch=%0d cnt=%0d ovf=%b",
                     tag, bf_ch, bf_count, bf_ovf, exp_ch, exp_cnt, e.ovf);
          end
          if (!e.ovf) begin
            n_vec++;
            if (last_beat[e.ch] !== 1'b1) begin
              n_err++;
              $display("FAIL %s latency: beat[%0d] before strobe=%b, required 1", tag, e.ch, last_beat[e.ch]);
            end
          end
          if (exp_q.size() == 0) done = 1;
        end
      end
      if (!done) begin
        start = poke && (t == 3);
        if (start) begin ch_en = 4'hF; stress_cycles = 16'd1; end
        tick();
        start = 1'b0;
        ch_en = 4'b0;
        t++;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: %0d results missing, required 0", tag, exp_q.size());
    end
    n_vec++;
    if (stress_seen != stress || viol != 0) begin
      n_err++;
      $display("FAIL %s stress: cycles=%0d bad=%0d, required cycles=%0d bad=0", tag, stress_seen, viol, stress);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || en_rosc !== 1'b0 || meas !== 1'b0 || en_power !== 4'b0) begin
      n_err++;
      $display("FAIL %s idle: busy=%b rosc=%b meas=%b pwr=%b, required all 0", tag, busy, en_rosc, meas, en_power);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; ac_dc = 1'b0;
    ch_en = 4'b0; stress_cycles = 16'd0; beat = 4'b0;
    for (int c = 0; c < NCH; c++) begin period[c] = 0; phase[c] = 0; end
    repeat (3) tick();
    n_vec++;
    if ({en_power, en_rosc, meas, acdc_lat, busy} !== 8'b0) begin
      n_err++;
      $display("FAIL reset ctrl: pwr=%b rosc=%b meas=%b acdc=%b busy=%b, required 0",
               en_power, en_rosc, meas, acdc_lat, busy);
    end
    n_vec++;
    if ({sel_ch, bf_count, bf_ch, bf_valid, bf_ovf} !== 18'b0) begin
      n_err++;
      $display("FAIL reset result: sel=%0d cnt=%0d ch=%0d v=%b o=%b, required 0",
               sel_ch, bf_count, bf_ch, bf_valid, bf_ovf);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_two_channel();
    int lat;
    period[0] = 37; period[2] = 37; period[1] = 11; period[3] = 13;
    for (int c = 0; c < NCH; c++) phase[c] = $urandom_range(0, 36);
    run_and_check("two_channel", 4'b0101, 10, 1'b1, lat);
  endtask

  task automatic test_timeout();
    int lat;
    for (int c = 0; c < NCH; c++) period[c] = 0;
    period[0] = 9;
    run_and_check("timeout", 4'b1000, 0, 1'b0, lat);
    n_vec++;
    if (lat != 1 + SETTLE + CMAX) begin
      n_err++;
      $display("FAIL timeout latency: %0d cycles, required %0d", lat, 1 + SETTLE + CMAX);
    end
  endtask

  task automatic test_long_period();
    int lat;
    for (int c = 0; c < NCH; c++) period[c] = 0;
    period[0] = 5000;
    phase[0]  = $urandom_range(0, 4999);
    run_and_check("long_period", 4'b0001, 3, 1'b0, lat);
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] m;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < NCH; c++) begin
        period[c] = $urandom_range(2, 300);
        phase[c]  = $urandom_range(0, 299);
      end
      m = 4'($urandom_range(1, 15));
      run_and_check("random", m, $urandom_range(0, 20), 1'b0, lat);
    end
  endtask

  task automatic test_continuous();
    int t, nv, stress_between, valid_seen, busy_seen;
    for (int c = 0; c < NCH; c++) period[c] = 0;
    period[0] = 20;
    phase[0]  = $urandom_range(0, 19);
    ch_en = 4'b0001; stress_cycles = 16'd5; continuous = 1'b1; ac_dc = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; continuous = 1'b0; ch_en = 4'b0;
    nv = 0; stress_between = 0; t = 0;
    while (nv < 2 && t < 2000) begin
      if (nv == 1 && en_power != 4'b0) stress_between++;
      if (bf_valid === 1'b1) begin
        nv++;
        n_vec++;
        if (bf_ch !== 2'd0 || bf_count !== 12'd20 || bf_ovf !== 1'b0) begin
          n_err++;
          $display("FAIL continuous result: ch=%0d cnt=%0d ovf=%b, required ch=0 cnt=20 ovf=0", bf_ch, bf_count, bf_ovf);
        end
      end
      if (nv < 2) begin tick(); t++; end
    end
    n_vec++;
    if (nv != 2 || stress_between != 5) begin
      n_err++;
      $display("FAIL continuous loop: results=%0d stress=%0d, required results=2 stress=5", nv, stress_between);
    end
    period[0] = 0;
    t = 0;
    while (en_power == 4'b0 && t < 100) begin tick(); t++; end
    while (en_power != 4'b0 && t < 200) begin tick(); t++; end
    repeat (10) tick();
    force_beat = 4'b0001;
    tick();
    force_beat = 4'b0;
    repeat (5) tick();
    n_vec++;
    if (busy !== 1'b1 || meas !== 1'b1 || bf_valid !== 1'b0 || t >= 200) begin
      n_err++;
      $display("FAIL continuous counting: busy=%b meas=%b valid=%b t=%0d, required 1 1 0 <200", busy, meas, bf_valid, t);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || en_rosc !== 1'b0 || meas !== 1'b0 || bf_valid !== 1'b0 || en_power !== 4'b0) begin
      n_err++;
      $display("FAIL stop: busy=%b rosc=%b meas=%b valid=%b pwr=%b, required all 0", busy, en_rosc, meas, bf_valid, en_power);
    end
    valid_seen = 0; busy_seen = 0;
    repeat (50) begin
      tick();
      if (bf_valid === 1'b1) valid_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    n_vec++;
    if (valid_seen != 0 || busy_seen != 0) begin
      n_err++;
      $display("FAIL after stop: valid=%0d busy=%0d, required 0 0", valid_seen, busy_seen);
    end
  endtask

  task automatic test_reset_mid_run();
    int busy_seen;
    period[0] = 37; period[1] = 37;
    ch_en = 4'b0011; stress_cycles = 16'd50; ac_dc = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; ch_en = 4'b0;
    repeat (10) tick();
    n_vec++;
    if (en_power !== 4'b0011 || acdc_lat !== 1'b1) begin
      n_err++;
      $display("FAIL pre-reset stress: pwr=%b acdc=%b, required 0011 1", en_power, acdc_lat);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({en_power, en_rosc, meas, acdc_lat, busy, sel_ch, bf_count, bf_ch, bf_valid, bf_ovf} !== 26'b0) begin
      n_err++;
      $display("FAIL mid-run reset: pwr=%b rosc=%b meas=%b acdc=%b busy=%b sel=%0d cnt=%0d ch=%0d v=%b o=%b, required 0",
               en_power, en_rosc, meas, acdc_lat, busy, sel_ch, bf_count, bf_ch, bf_valid, bf_ovf);
    end
    ch_en = 4'b0; stress_cycles = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    busy_seen = (busy !== 1'b0) ? 1 : 0;
    repeat (5) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
    end
    n_vec++;
    if (busy_seen != 0) begin
      n_err++;
      $display("FAIL empty-mask start: busy cycles=%0d, required 0", busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_two_channel();
    test_timeout();
    test_long_period();
    test_random();
    test_continuous();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
